// File: rtl/mul256_seq_ctrl.sv
// Sequential 256x256 unsigned multiplier controller: streams four 64-bit B chunks
// through an external 256x64 booth_top multiplier and accumulates the partial products.
module mul256_seq_ctrl #(
    parameter int NCHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clr,
    input  logic [255:0] a,
    input  logic [255:0] b,
    output logic         busy,
    output logic         done,
    output logic [511:0] p,
    output logic [255:0] mul_a,
    output logic [63:0]  mul_b,
    input  logic [319:0] mul_p
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] LAST = 2'(NCHUNK - 1);

    logic [1:0]   state;
    logic [1:0]   cnt;
    logic [255:0] a_reg;
    logic [255:0] b_reg;
    logic [511:0] acc;
    logic [511:0] sum;

    assign busy  = (state == CALC);
    assign done  = (state == DONE);
    // Operands are forced to zero outside CALC so the external multiplier stays quiet.
    assign mul_a = busy ? a_reg : '0;
    assign mul_b = busy ? b_reg[{cnt, 6'd0} +: 64] : '0;
    assign sum   = acc + ({192'd0, mul_p} << {cnt, 6'd0});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            p     <= '0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                CALC: begin
                    acc <= sum;
                    cnt <= cnt + 2'd1;
                    // cnt wraps back to 0 on this same edge
                    if (cnt == LAST) begin
                        p     <= sum;
                        state <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul256_seq_ctrl.sv
// Scoreboard bench for mul256_seq_ctrl: stimulus pushes expected products, a negedge
// monitor checks product, latency, operand streaming, p hold and reset behaviour.
module tb_mul256_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         clr = 1'b0;
    logic [255:0] a_i = '0;
    logic [255:0] b_i = '0;
    logic         busy;
    logic         done;
    logic [511:0] p;
    logic [255:0] mul_a;
    logic [63:0]  mul_b;
    logic [319:0] mul_p;

    always #5 clk = ~clk;

    // behavioural stand-in for the external booth_top
    assign mul_p = {64'd0, mul_a} * {256'd0, mul_b};

    mul256_seq_ctrl #(.NCHUNK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clr   (clr),
        .a     (a_i),
        .b     (b_i),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_p (mul_p)
    );

    typedef struct {
        logic [255:0] a;
        logic [255:0] b;
        logic [511:0] e;
        int           t;
    } op_t;

    op_t          q[$];
    int           cyc = 0;
    int           tests = 0;
    int           fails = 0;
    logic [511:0] hold = '0;
    bit           fin = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        op_t o;
        int  idx;
        if (!rst_n) begin
            tests++;
            if (busy !== 1'b0 || done !== 1'b0 || p !== '0 || mul_a !== '0 || mul_b !== '0) begin
                fails++;
                $display("FAIL reset_outputs: busy=%b done=%b p=%h mul_a=%h mul_b=%h, want all zero",
                         busy, done, p, mul_a, mul_b);
            end
            hold = '0;
        end else begin
            tests++;
            if (busy && done) begin
                fails++;
                $display("FAIL busy_done_excl: busy=%b done=%b, want never both 1", busy, done);
            end
            if (done) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done=1 with no operation outstanding, want done=0");
                end else begin
                    o = q.pop_front();
                    idx = cyc - o.t;
                    if (p !== o.e) begin
                        fails++;
                        $display("FAIL product: p=%h want %h", p, o.e);
                    end
                    tests++;
                    if (idx != 4) begin
                        fails++;
                        $display("FAIL latency: done %0d cycles after accept edge, want 4", idx);
                    end
                    hold = o.e;
                end
                tests++;
                if (mul_a !== '0 || mul_b !== '0) begin
                    fails++;
                    $display("FAIL isolation_done: mul_a=%h mul_b=%h, want 0", mul_a, mul_b);
                end
            end else begin
                tests++;
                if (p !== hold) begin
                    fails++;
                    $display("FAIL p_hold: p=%h want %h", p, hold);
                end
                if (busy) begin
                    if (q.size() > 0) begin
                        o = q[0];
                        idx = cyc - o.t;
                        tests++;
                        if (idx < 0 || idx > 3) begin
                            fails++;
                            $display("FAIL busy_window: busy %0d cycles after accept edge, want 0..3", idx);
                        end else if (mul_a !== o.a || mul_b !== o.b[idx*64 +: 64]) begin
                            fails++;
                            $display("FAIL operands: chunk %0d mul_b=%h want %h, mul_a ok=%b",
                                     idx, mul_b, o.b[idx*64 +: 64], mul_a === o.a);
                        end
                    end
                end else begin
                    tests++;
                    if (mul_a !== '0 || mul_b !== '0) begin
                        fails++;
                        $display("FAIL isolation_idle: mul_a=%h mul_b=%h, want 0", mul_a, mul_b);
                    end
                end
            end
        end
        if (fin || cyc > 60000) begin
            tests++;
            if (cyc > 60000) begin
                fails++;
                $display("FAIL watchdog: cycle %0d exceeded budget 60000", cyc);
            end else if (q.size() != 0) begin
                fails++;
                $display("FAIL pending_ops: %0d operations never completed, want 0", q.size());
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        case ($urandom_range(7))
            0: v = '1;
            1: v[255:64] = '0;
            2: v[127:64] = '0;
            default: ;
        endcase
        return v;
    endfunction

    // Issue one op; returns #1 into its DONE cycle so a following op goes back-to-back.
    task automatic op(input logic [255:0] x, input logic [255:0] y, input logic [511:0] e);
        a_i   = x;
        b_i   = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{x, y, e, cyc});
        start = 1'b0;
        a_i   = ~x;
        b_i   = ~y;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start an op that is cleared k cycles into CALC; nothing is expected from it.
    task automatic abort(input int k);
        a_i   = r256();
        b_i   = r256();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    initial begin : stim
        logic [255:0] ba[4];
        logic [255:0] bb[4];
        logic [511:0] be[4];
        logic [255:0] x;
        logic [255:0] y;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        op(256'd1, 256'd1, 512'd1);
        idle(2);
        x = 256'h89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524;
        y = {192'h0, 64'h1e8dcd3d3b23f176};
        op(x, y, 512'(x) * 512'(y));
        idle(1);
        op('1, '1, {{63{4'hf}}, 4'he, {63{4'h0}}, 4'h1});
        op(256'd1 << 255, 256'd2, 512'd1 << 256);
        op(256'd0, '1, 512'd0);
        op(256'd3, 256'd1 << 192, 512'd3 << 192);
        idle(2);

        // clr beats start in IDLE
        a_i   = 256'd5;
        b_i   = 256'd7;
        start = 1'b1;
        clr   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        clr   = 1'b0;
        idle(6);

        // start held high; operands change during CALC and must be ignored
        ba[0] = 256'd2;            bb[0] = 256'd3;            be[0] = 512'd6;
        ba[1] = 256'hffff_ffff_ffff_ffff; bb[1] = 256'hffff_ffff_ffff_ffff;
        be[1] = 512'hffff_ffff_ffff_fffe_0000_0000_0000_0001;
        ba[2] = 256'd1 << 255;     bb[2] = 256'd1 << 255;     be[2] = 512'd1 << 510;
        ba[3] = 256'd12345;        bb[3] = 256'd1000;         be[3] = 512'd12345000;
        a_i   = ba[0];
        b_i   = bb[0];
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            q.push_back('{ba[k], bb[k], be[k], cyc});
            a_i = r256();
            b_i = r256();
            repeat (3) @(posedge clk);
            #1;
            if (k < 3) begin
                a_i = ba[k+1];
                b_i = bb[k+1];
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        idle(2);

        // clr in the 2nd CALC cycle: no done, p keeps 12345000
        abort(1);
        idle(5);

        // reset in the 3rd CALC cycle
        a_i   = r256();
        b_i   = r256();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        op(256'd7, 256'd9, 512'd63);
        idle(1);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(9) == 0) begin
                abort($urandom_range(3));
            end else begin
                x = r256();
                y = r256();
                op(x, y, 512'(x) * 512'(y));
            end
            idle($urandom_range(2));
        end
        idle(8);
        fin = 1'b1;
    end

endmodule
